muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle multiply/divide unit: radix-2 shift-add multiply, restoring divide.
//   Sits beside the ALU in the execute stage. MULT/DIV opcodes go here, not to ALU_MULT/ALU_DIV.
//   Produces MIPS-style HI/LO results; the pipeline stalls on busy.
// PARAMETERS
//   WIDTH   32   operand width; product is 2*WIDTH bits, split across hi/lo
// PORTS
//   clock        in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      request a new operation; accepted only when busy==0
//   op           in   1      0 = multiply, 1 = divide
//   is_signed    in   1      1 = two's-complement operands (see CONFIGURATION)
//   a            in   WIDTH  multiplicand / dividend
//   b            in   WIDTH  multiplier / divisor
//   busy         out  1      operation in flight; start ignored while high
//   done         out  1      one-cycle pulse: hi/lo/div_by_zero valid
//   hi           out  WIDTH  mult: product[2W-1:W]; div: remainder
//   lo           out  WIDTH  mult: product[W-1:0];  div: quotient
//   div_by_zero  out  1      set with done when op=1 and b==0; held until next accept
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0. Reset mid-operation
//     aborts it; no done pulse is produced for the aborted operation.
//   FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//     IDLE: start=1 latches a, b, op and is_signed; converts operands to magnitudes when signed.
//       Loads counter=WIDTH and goes to RUN. If op=1 and b==0 it goes to DONE directly.
//     RUN: one iteration per cycle; the counter decrements; at 1 it goes to FIX.
//     FIX: applies sign correction and writes hi/lo; goes to DONE.
//     DONE: done=1 for exactly this cycle; busy=0. start here is accepted, same as IDLE.
//   busy=1 in RUN and FIX only. Latency: start accepted at edge t -> done high t+WIDTH+2.
//     Divide-by-zero case: done at t+1.
//   Operands are captured at accept; later changes on a/b/op/is_signed have no effect.
//   start while busy=1: ignored, not queued.
//   hi/lo hold their last result from done until the next FIX or div-by-zero write.
//     They are not cleared on accept.
//   Multiply: {hi,lo} = a*b, exact, 2*WIDTH bits. No overflow flag.
//   Divide: restoring, one quotient bit per cycle. Partial remainder is WIDTH+1 bits.
//   Signed divide:
//     - quotient truncates toward zero; remainder takes the dividend's sign
//     - -2^(W-1) / -1 -> lo=2^(W-1) (wraps), hi=0
//   Divide by zero: lo = all ones, hi = a (raw), div_by_zero=1.
//   div_by_zero clears on the next accepted start.
//   Signed multiply: product negated in FIX when sign(a)^sign(b).
// CONFIGURATION
//   MULDIV_SIGNED_EN defined:
//     - is_signed is honoured
//     - magnitude conversion in IDLE, negation in FIX
//   MULDIV_SIGNED_EN undefined:
//     - is_signed is ignored; all operations are unsigned
//     - sign logic is not built
//     - the FIX state stays (latency is unchanged) and only writes hi/lo
// TESTING
//   1. Unsigned mult: a=0xFFFFFFFF, b=0xFFFFFFFF, op=0.
//      -> done at t+34; hi=0xFFFFFFFE, lo=0x00000001.
//   2. Signed mult (EN): a=-3, b=7, is_signed=1.
//      -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without EN -> hi=0x00000006, lo=0xFFFFFFEB.
//   3. Divide: a=100, b=7, op=1 -> lo=14, hi=2.
//      Signed (EN) a=-100, b=7 -> lo=-14, hi=-2.
//   4. Div by zero: a=0x1234, b=0, op=1.
//      -> done at t+1; lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
//   5. Handshake:
//      - start pulses during RUN are ignored; a/b changed mid-RUN do not alter the result
//      - start held high in the DONE cycle starts a back-to-back op; done spacing = 34 cycles
//   6. Reset asserted mid-RUN (cycle t+10).
//      -> busy=0, hi=lo=0 immediately; no done pulse; the next op completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide unit that sits beside the ALU.
// Multiply is radix-2 shift-add and divide is restoring; both retire one bit per
// cycle. Results are MIPS-style HI/LO.
//
// Optional feature macro: MULDIV_SIGNED_EN. When it is defined, is_signed is
// honoured: operands are converted to magnitudes at accept, and the result is
// negated in FIX. When it is not defined, every operation is unsigned and
// is_signed is ignored.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start, op         request (accepted only when busy==0); 0=multiply, 1=divide
//   is_signed         two's-complement operands (MULDIV_SIGNED_EN builds only)
//   a, b              multiplicand/dividend, multiplier/divisor
//   busy              high in RUN and FIX
//   done              one-cycle pulse when hi/lo/div_by_zero are valid
//   hi, lo            mult: product high/low half; div: remainder/quotient
//   div_by_zero       set with done on divide by zero, held until next accept
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               op_r;
  logic [WIDTH-1:0]   acc;     // mult: running high half; div: partial remainder
  logic [WIDTH-1:0]   qr;      // mult: multiplier / low product; div: dividend / quotient
  logic [WIDTH-1:0]   opb;     // mult: multiplicand; div: divisor
  logic [WIDTH-1:0]   ma, mb;
  logic [WIDTH:0]     msum, dsh, dtrial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               accept, dbz_req;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign dbz_req = op && (b == '0);

`ifdef MULDIV_SIGNED_EN
  logic sa, sb;
  logic neg_hi, neg_lo;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  assign sa = is_signed & a[WIDTH-1];
  assign sb = is_signed & b[WIDTH-1];
  assign ma = cneg(a, sa);
  assign mb = cneg(b, sb);
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign ma = a;
  assign mb = b;
`endif

  // One iteration of each algorithm. The divide trial subtraction is WIDTH+1
  // bits wide so a borrow shows up in the top bit even when the shifted
  // remainder exceeds WIDTH bits.
  always_comb begin
    msum   = {1'b0, acc} + (qr[0] ? {1'b0, opb} : '0);
    dsh    = {acc, qr[WIDTH-1]};
    dtrial = dsh - {1'b0, opb};
  end

  // Final result formation, including sign correction when enabled.
  always_comb begin
    prod = {acc, qr};
`ifdef MULDIV_SIGNED_EN
    prod = cneg2(prod, neg_lo);
    if (op_r) begin
      fix_hi = cneg(acc, neg_hi);
      fix_lo = cneg(qr, neg_lo);
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
`else
    fix_hi = op_r ? acc : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_r ? qr  : prod[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = dbz_req ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? (dbz_req ? DONE : RUN) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architectural results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      op_r        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_hi      <= 1'b0;
      neg_lo      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt         <= CW'(WIDTH);
        op_r        <= op;
        div_by_zero <= dbz_req;
`ifdef MULDIV_SIGNED_EN
        // Quotient/product sign is sa^sb; remainder follows the dividend.
        neg_lo      <= sa ^ sb;
        neg_hi      <= op ? sa : (sa ^ sb);
`endif
        if (dbz_req) begin
          hi <= a;
          lo <= '1;
        end
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

  // Iteration datapath; contents are don't-care until loaded at accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      acc <= '0;
      qr  <= op ? ma : mb;
      opb <= op ? mb : ma;
    end else if (state == RUN) begin
      if (op_r) begin
        if (!dtrial[WIDTH]) begin
          acc <= dtrial[WIDTH-1:0];
          qr  <= {qr[WIDTH-2:0], 1'b1};
        end else begin
          acc <= dsh[WIDTH-1:0];
          qr  <= {qr[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= msum[WIDTH:1];
        qr  <= {msum[0], qr[WIDTH-1:1]};
      end
    end
  end

endmodule
